// File: rtl/ram_bist_ctrl.sv
// Self-test initiator for a simple write-port/read-port RAM: writes seed^addr to every
// location, reads everything back through a latency-matched compare pipe and reports the result.
module ram_bist_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] seed,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_fail_addr
);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};
    localparam int                 DRAIN_W    = $clog2(RD_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);
    localparam int                 XOR_W      = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [DATA_W-1:0]  seed_r, seed_s;
    logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_s;
    logic               launch_s, flush_s, mis_s;
    logic               wr_en_s, rd_en_s, busy_s, done_s, pass_s;
    logic [ADDR_W-1:0]  wr_addr_s, rd_addr_s, ffa_s;
    logic [DATA_W-1:0]  wr_data_s;
    logic [ERR_W-1:0]   err_s;
    logic [RD_LAT:1]    pv_r;
    logic [ADDR_W-1:0]  pa_r [1:RD_LAT];

    // Pattern: seed XOR address, address zero-extended or truncated to the data width.
    function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] s,
                                                   input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] ax;
        ax = '0;
        for (int i = 0; i < XOR_W; i++) begin
            ax[i] = a[i];
        end
        return s ^ ax;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort outranks both start and normal sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) state_s = ST_WRITE;
                else                 state_s = state_r;
            end
            ST_WRITE: begin
                if (abort)                      state_s = ST_IDLE;
                else if (wr_addr == LAST_ADDR)  state_s = ST_READ;
                else                            state_s = ST_WRITE;
            end
            ST_READ: begin
                if (abort)                      state_s = ST_IDLE;
                else if (rd_addr == LAST_ADDR)  state_s = ST_DRAIN;
                else                            state_s = ST_READ;
            end
            ST_DRAIN: begin
                if (abort)                           state_s = ST_IDLE;
                else if (drain_cnt_r == DRAIN_LAST)  state_s = ST_DONE;
                else                                 state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered RAM-side and status outputs
    always_comb begin
        launch_s    = (state_s == ST_WRITE) && (state_r != ST_WRITE);
        flush_s     = abort && ((state_r == ST_WRITE) || (state_r == ST_READ) ||
                                (state_r == ST_DRAIN));
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        wr_addr_s   = wr_addr;
        rd_addr_s   = rd_addr;
        drain_cnt_s = drain_cnt_r;
        if (launch_s) seed_s = seed;
        else          seed_s = seed_r;
        case (state_s)
            ST_WRITE: begin
                wr_en_s = 1'b1;
                if (launch_s) wr_addr_s = '0;
                else          wr_addr_s = wr_addr + 1'b1;
            end
            ST_READ: begin
                rd_en_s = 1'b1;
                if (state_r == ST_READ) rd_addr_s = rd_addr + 1'b1;
                else                    rd_addr_s = '0;
            end
            ST_DRAIN: begin
                if (state_r == ST_DRAIN) drain_cnt_s = drain_cnt_r + 1'b1;
                else                     drain_cnt_s = '0;
            end
            ST_IDLE, ST_DONE: begin
                drain_cnt_s = '0;
            end
            default: begin
                drain_cnt_s = '0;
            end
        endcase
        wr_data_s = exp_data(seed_s, wr_addr_s);
        busy_s    = (state_s == ST_WRITE) || (state_s == ST_READ) || (state_s == ST_DRAIN);
        done_s    = (state_s == ST_DONE);
    end

    // Result bookkeeping: the oldest pipe entry meets its rd_data on this edge
    always_comb begin
        mis_s = pv_r[RD_LAT] && !flush_s && (rd_data != exp_data(seed_r, pa_r[RD_LAT]));
        if (launch_s) begin
            err_s = '0;
            ffa_s = '0;
        end else if (mis_s) begin
            if (err_count != ERR_MAX) err_s = err_count + 1'b1;
            else                      err_s = err_count;
            if (err_count == '0) ffa_s = pa_r[RD_LAT];
            else                 ffa_s = first_fail_addr;
        end else begin
            err_s = err_count;
            ffa_s = first_fail_addr;
        end
        pass_s = (state_s == ST_DONE) && (err_s == '0);
    end

    // Registered outputs and per-run context
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            seed_r          <= '0;
            drain_cnt_r     <= '0;
        end else begin
            wr_en           <= wr_en_s;
            wr_addr         <= wr_addr_s;
            wr_data         <= wr_data_s;
            rd_en           <= rd_en_s;
            rd_addr         <= rd_addr_s;
            busy            <= busy_s;
            done            <= done_s;
            pass            <= pass_s;
            err_count       <= err_s;
            first_fail_addr <= ffa_s;
            seed_r          <= seed_s;
            drain_cnt_r     <= drain_cnt_s;
        end
    end

    // Compare pipe: stage 0 is the rd_en/rd_addr register itself, stages 1..RD_LAT follow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv_r <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                pa_r[i] <= '0;
            end
        end else begin
            if (flush_s) begin
                pv_r <= '0;
            end else begin
                pv_r[1] <= rd_en;
                for (int i = 2; i <= RD_LAT; i++) begin
                    pv_r[i] <= pv_r[i-1];
                end
            end
            pa_r[1] <= rd_addr;
            for (int i = 2; i <= RD_LAT; i++) begin
                pa_r[i] <= pa_r[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: three instances (RD_LAT=1, RD_LAT=3, ERR_W=2) run side by side
// against behavioural RAMs with configurable latency and read corruption.
module tb_ram_bist_ctrl;
    localparam int NI    = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start, abort;
    logic [7:0] seed;
    logic       wr_en [NI];
    logic       rd_en [NI];
    logic [3:0] wr_addr [NI];
    logic [3:0] rd_addr [NI];
    logic [7:0] wr_data [NI];
    logic [7:0] rd_data [NI];
    logic       busy [NI];
    logic       done [NI];
    logic       pass [NI];
    logic [3:0] ffa [NI];
    logic [7:0] err0, err1;
    logic [1:0] err2;

    int         rd_lat_cfg [NI] = '{1, 3, 1};
    int         err_max [NI]    = '{255, 255, 3};
    int         ram_lat [NI];
    logic [7:0] cor [NI][DEPTH];
    logic [7:0] mem [NI][DEPTH];
    logic [7:0] line [NI][4];
    int         n_cmp = 0;
    int         n_mis = 0;

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .ERR_W(8)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .seed(seed),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .first_fail_addr(ffa[0]));
    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .ERR_W(8)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .seed(seed),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .first_fail_addr(ffa[1]));
    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .ERR_W(2)) u2 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .seed(seed),
        .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err2), .first_fail_addr(ffa[2]));

    // RAM models: write on the edge, read data travels down a delay line, corruption applied on read
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rstn) begin
                for (int j = 0; j < 4; j++) line[i][j] <= 8'h00;
            end else begin
                if (wr_en[i]) mem[i][wr_addr[i]] <= wr_data[i];
                for (int j = 3; j > 0; j--) line[i][j] <= line[i][j-1];
                line[i][0] <= rd_en[i] ? (mem[i][rd_addr[i]] ^ cor[i][rd_addr[i]]) : 8'h00;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) rd_data[i] = line[i][ram_lat[i]-1];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_err(input int i);
        case (i)
            0:       return {24'd0, err0};
            1:       return {24'd0, err1};
            default: return {30'd0, err2};
        endcase
    endfunction

    // Reference: compare i of address a sees whatever the RAM read (RD_LAT - ram latency) slots later
    task automatic predict(input int i, input logic [7:0] s, output int errs, output int ffa_e);
        int         d;
        logic [7:0] obs;
        errs  = 0;
        ffa_e = 0;
        d     = rd_lat_cfg[i] - ram_lat[i];
        for (int a = 0; a < DEPTH; a++) begin
            if (a + d >= 0 && a + d < DEPTH) obs = (s ^ 8'(a + d)) ^ cor[i][a + d];
            else                             obs = 8'h00;
            if (obs != (s ^ 8'(a))) begin
                if (errs == 0) ffa_e = a;
                errs++;
            end
        end
        if (errs > err_max[i]) errs = err_max[i];
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_out%0d", tag, i),
                      {7'd0, wr_en[i], rd_en[i], busy[i], done[i], pass[i],
                       wr_addr[i], rd_addr[i], wr_data[i], ffa[i]}, 32'd0);
            check_val($sformatf("%s_err%0d", tag, i), get_err(i), 32'd0);
        end
    endtask

    task automatic set_healthy();
        ram_lat = '{1, 3, 1};
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < DEPTH; a++) cor[i][a] = 8'h00;
    endtask

    // One run; abort_n is the edge offset from the start edge where abort is sampled (-1 none),
    // spur_n raises start once mid-run (-1 none)
    task automatic run_bist(input logic [7:0] s, input int abort_n, input int spur_n);
        int         ee [NI];
        int         ef [NI];
        logic       xw, xr, xb;
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed  = 8'($urandom);
        for (int i = 0; i < NI; i++) predict(i, s, ee[i], ef[i]);
        for (int n = 0; n <= 36; n++) begin
            if (n == abort_n) begin
                for (int i = 0; i < NI; i++) begin
                    check_val($sformatf("abort_ctl%0d", i),
                              {28'd0, wr_en[i], rd_en[i], busy[i], done[i]}, 32'd0);
                    check_val($sformatf("abort_err%0d", i), get_err(i), 32'd0);
                end
                abort = 1'b0;
                @(posedge clk);
                #1;
                for (int i = 0; i < NI; i++)
                    check_val($sformatf("idle_ctl%0d", i),
                              {28'd0, wr_en[i], rd_en[i], busy[i], done[i]}, 32'd0);
                return;
            end
            for (int i = 0; i < NI; i++) begin
                xw = (n <= 15);
                xr = (n >= 16 && n <= 31);
                xb = (n < 32 + rd_lat_cfg[i]);
                check_val($sformatf("ctl%0d_n%0d", i, n),
                          {28'd0, wr_en[i], rd_en[i], busy[i], done[i]},
                          {28'd0, xw, xr, xb, !xb});
                if (xw) check_val($sformatf("wr%0d_n%0d", i, n), {20'd0, wr_addr[i], wr_data[i]},
                                  {20'd0, 4'(n), s ^ 8'(n)});
                if (xr) check_val($sformatf("rd%0d_n%0d", i, n), {28'd0, rd_addr[i]},
                                  {28'd0, 4'(n - 16)});
                if (n == 36) begin
                    check_val($sformatf("err%0d", i), get_err(i), 32'(ee[i]));
                    check_val($sformatf("ffa%0d", i), {28'd0, ffa[i]}, 32'(ef[i]));
                    check_val($sformatf("pass%0d", i), {31'd0, pass[i]}, {31'd0, ee[i] == 0});
                end
            end
            if (n < 36) begin
                abort = (n + 1 == abort_n);
                start = (n == spur_n);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed  = 8'h00;
        set_healthy();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("idle");

        // Clean run with the documented seed
        run_bist(8'hA5, -1, -1);

        // Faults: two flipped bits, latency-2 RAM under RD_LAT=3, every cell bad under ERR_W=2
        cor[0][6]  = 8'h01;
        cor[0][11] = 8'h01;
        ram_lat[1] = 2;
        for (int a = 0; a < DEPTH; a++) cor[2][a] = 8'h01;
        run_bist(8'($urandom), -1, -1);

        // Healthy restart from DONE must clear the counters
        set_healthy();
        run_bist(8'($urandom), -1, -1);

        // Abort in the fifth read cycle, then a full clean run
        run_bist(8'h5A, 21, -1);
        run_bist(8'($urandom), -1, -1);

        // Asynchronous reset in the middle of the write phase
        seed  = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check_all_zero("rst_rel");
        run_bist(8'($urandom), -1, -1);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            ram_lat[0] = ($urandom_range(3) == 0) ? int'($urandom_range(4, 2)) : 1;
            ram_lat[1] = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 2 : 4) : 3;
            ram_lat[2] = ($urandom_range(3) == 0) ? int'($urandom_range(4, 2)) : 1;
            for (int i = 0; i < NI; i++)
                for (int a = 0; a < DEPTH; a++)
                    cor[i][a] = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_bist(8'($urandom), -1, ($urandom_range(1) == 0) ? int'($urandom_range(28, 1)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Hardware initiator for the single-port-pair RAM interface (clk, rstn, wr_en, rd_en, wr_addr, rd_addr, wr_data, rd_data). It sits on the initiator side and drives the RAM's write and read ports.
- On start, it writes a deterministic pattern to every address, reads every address back, and compares against the expected data with a configurable read latency.
- It reports busy/done/pass, a saturating error count, and the first failing address. It is used as an on-chip self-test and as a synthesizable traffic source in RAM regressions.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from the edge at which the RAM samples rd_en to the edge at which rd_data is valid. Legal range is 1..4.
- ERR_W, 8, error counter width.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- start, input, 1, level; sampled in IDLE or DONE to begin a run.
- abort, input, 1, sampled every cycle; terminates a run.
- seed, input, DATA_W, pattern seed, captured when start is accepted.
- wr_en, output, 1, RAM write enable.
- wr_addr, output, ADDR_W, RAM write address.
- wr_data, output, DATA_W, RAM write data.
- rd_en, output, 1, RAM read enable.
- rd_addr, output, ADDR_W, RAM read address.
- rd_data, input, DATA_W, RAM read data.
- busy, output, 1, high in WRITE, READ and DRAIN.
- done, output, 1, high in DONE.
- pass, output, 1, valid while done=1; 1 iff no mismatch occurred.
- err_count, output, ERR_W, number of mismatches; saturates at 2**ERR_W-1.
- first_fail_addr, output, ADDR_W, address of the first mismatch in the run.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, the captured seed is 0, and the compare pipe is empty. The async assert takes effect immediately, including mid-run.
- Expected data: exp(a) = seed_q XOR zero-extend(a). If DATA_W < ADDR_W, a is truncated to DATA_W bits.
- States and transitions:
  - IDLE: start=1 → WRITE. On entry, capture seed, clear err_count/first_fail_addr/pass, and set wr_en=1, wr_addr=0, wr_data=exp(0).
  - WRITE: one write per cycle, with wr_addr incrementing by 1.
    - At the edge where the issued wr_addr == DEPTH-1, go to READ: wr_en=0, rd_en=1, rd_addr=0.
    - wr_en and rd_en are never high in the same cycle.
  - READ: one read per cycle, with rd_addr incrementing. After rd_addr == DEPTH-1 is issued, go to DRAIN with rd_en=0.
  - DRAIN: stay exactly RD_LAT cycles so that every outstanding compare completes, then go to DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). Hold until start=1, which re-enters WRITE as from IDLE in the same cycle.
- Compare pipe:
  - A valid/address shift register of depth RD_LAT+1 tracks each read.
  - A read issued in cycle k (rd_en high) is compared against rd_data sampled at the edge ending cycle k+RD_LAT.
  - On mismatch, err_count increments (saturating). If this is the run's first mismatch, first_fail_addr latches that address.
- Run length: DEPTH write cycles + DEPTH read cycles + RD_LAT drain cycles. Given start sampled at edge E0, done rises at E0 + 2*DEPTH + RD_LAT.
- Abort:
  - abort=1 at any edge in WRITE/READ/DRAIN forces IDLE at that edge.
  - wr_en, rd_en, busy and done go to 0, and the compare pipe is flushed. err_count and first_fail_addr hold their values.
  - abort has priority over start. abort in IDLE/DONE has no effect other than blocking start.
- start while busy is ignored.
- Address counters wrap only by the state change; no address beyond DEPTH-1 is ever issued.

Test Plan:
- Clean run: ADDR_W=4, DATA_W=8, RD_LAT=1, seed=8'hA5, ideal RAM → wr_data sequence A5,A4,A7,…,AA (seed^addr); done at E0+33; pass=1, err_count=0.
- Fault injection: RAM model flips bit 0 of location 6 and location 11 → err_count=2, first_fail_addr=6, pass=0.
- Latency: RD_LAT=3 with a matching RAM model → pass=1, done at E0+35. Separately, a RAM with latency 2 while RD_LAT=3 → err_count ≥15, pass=0.
- Abort: assert abort in the 5th READ cycle → next cycle IDLE, rd_en=0, busy=0, done=0; then start again → full clean run passes with err_count cleared.
- Reset mid-run: deassert rstn asynchronously during WRITE → all outputs 0 immediately, without waiting for a clock edge. After release, start behaves as the first run.
- Saturation: ERR_W=2 with all 16 locations corrupted → err_count=3, first_fail_addr=0; restart from DONE with a healthy RAM → err_count=0, pass=1.
